// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: one full-adder cell computes a + ~b + 1
// LSB first, one bit per clock, with valid/ready handshakes on operands and result.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // Returns {carry_out, sum} of a single full-adder cell.
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic cin);
    full_add = {(x & y) | (x & cin) | (y & cin), x ^ y ^ cin};
  endfunction

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_diff;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic             r_a_msb;
  logic             r_b_msb;
  logic             r_out_valid;
  logic             r_borrow;
  logic             r_ovf;

  logic [1:0]       w_fa;
  logic             w_d;
  logic             w_carry;

  // Operands shift right so the current bit is always at position 0.
  assign w_fa    = full_add(r_a[0], ~r_b[0], r_carry);
  assign w_d     = w_fa[0];
  assign w_carry = w_fa[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_carry     <= 1'b1;
      r_out_valid <= 1'b0;
      r_diff      <= '0;
      r_borrow    <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= b;
            r_a_msb <= a[WIDTH-1];
            r_b_msb <= b[WIDTH-1];
            r_cnt   <= '0;
            r_carry <= 1'b1;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_a     <= r_a >> 1;
          r_b     <= r_b >> 1;
          r_diff  <= {w_d, r_diff[WIDTH-1:1]};
          r_carry <= w_carry;
          r_cnt   <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            // w_d is the result sign bit on this last step.
            r_out_valid <= 1'b1;
            r_borrow    <= ~w_carry;
            r_ovf       <= (r_a_msb != r_b_msb) && (w_d != r_a_msb);
            r_state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = r_out_valid;
  assign diff      = r_diff;
  assign borrow    = r_borrow;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and randomized checks of serial_subtractor at WIDTH = 8 and WIDTH = 2.
module tb_serial_subtractor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       in_valid, in_ready, out_valid, out_ready, borrow, ovf;
  logic [7:0] a, b, diff;
  logic       in_valid2, in_ready2, out_valid2, out_ready2, borrow2, ovf2;
  logic [1:0] a2, b2, diff2;

  int checks = 0;
  int errors = 0;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .diff(diff), .borrow(borrow), .ovf(ovf)
  );

  serial_subtractor #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2), .a(a2), .b(b2),
    .out_valid(out_valid2), .out_ready(out_ready2), .diff(diff2), .borrow(borrow2), .ovf(ovf2)
  );

  // Drives one operation on the 8-bit DUT with out_ready high; returns at posedge+1
  // after the result handshake. lat = 0 means out_valid never rose.
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_, output logic [7:0] d,
                        output logic bo, output logic ov, output int lat);
    out_ready = 1'b1;
    a = ta; b = tb_; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        lat = k;
        break;
      end
    end
    d = diff; bo = borrow; ov = ovf;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0; a = '0; b = '0; out_ready = 1'b0;
    in_valid2 = 1'b0; a2 = '0; b2 = '0; out_ready2 = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid: got %b expected 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset in_ready: got %b expected 1", in_ready); end
    checks++; if (diff !== 8'h00) begin errors++; $display("FAIL reset diff: got %h expected 00", diff); end
    checks++; if ({borrow, ovf} !== 2'b00) begin errors++; $display("FAIL reset flags: got %b%b expected 00", borrow, ovf); end
    checks++; if (in_ready2 !== 1'b1) begin errors++; $display("FAIL reset in_ready w2: got %b expected 1", in_ready2); end
  endtask

  task automatic test_basic();
    logic [7:0] d;
    logic bo, ov;
    int lat;
    run_op(8'd200, 8'd55, d, bo, ov, lat);
    checks++; if (lat !== 8) begin errors++; $display("FAIL basic latency: got %0d expected 8", lat); end
    checks++; if (d !== 8'd145) begin errors++; $display("FAIL basic diff: got %0d expected 145", d); end
    checks++; if ({bo, ov} !== 2'b00) begin errors++; $display("FAIL basic flags: got %b%b expected 00", bo, ov); end
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL basic after handshake: in_ready %b out_valid %b expected 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_arith();
    logic [7:0] va [6];
    logic [7:0] vb [6];
    logic [7:0] ed [6];
    logic       eb [6];
    logic       eo [6];
    logic [7:0] d;
    logic bo, ov;
    int lat;
    va = '{8'd10,  8'h80, 8'h7F, 8'h5A, 8'h00, 8'h93};
    vb = '{8'd20,  8'h01, 8'hFF, 8'h5A, 8'h01, 8'h00};
    ed = '{8'hF6,  8'h7F, 8'h80, 8'h00, 8'hFF, 8'h93};
    eb = '{1'b1,   1'b0,  1'b1,  1'b0,  1'b1,  1'b0};
    eo = '{1'b0,   1'b1,  1'b1,  1'b0,  1'b0,  1'b0};
    for (int i = 0; i < 6; i++) begin
      run_op(va[i], vb[i], d, bo, ov, lat);
      checks++; if (d !== ed[i]) begin errors++; $display("FAIL arith[%0d] diff: got %h expected %h", i, d, ed[i]); end
      checks++; if (bo !== eb[i]) begin errors++; $display("FAIL arith[%0d] borrow: got %b expected %b", i, bo, eb[i]); end
      checks++; if (ov !== eo[i]) begin errors++; $display("FAIL arith[%0d] ovf: got %b expected %b", i, ov, eo[i]); end
    end
  endtask

  task automatic test_backpressure();
    int k;
    out_ready = 1'b0;
    a = 8'hC3; b = 8'h3C; in_valid = 1'b1;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp busy in_ready: got %b expected 0", in_ready); end
    a = 8'h11; b = 8'h22;
    k = 0;
    while (!out_valid && k < 40) begin @(posedge clk); #1; k++; end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp timeout: out_valid %b expected 1", out_valid); end
    checks++; if ({diff, borrow, ovf} !== {8'h87, 2'b00}) begin
      errors++; $display("FAIL bp result: got %h %b%b expected 87 00", diff, borrow, ovf);
    end
    for (int i = 0; i < 6; i++) begin
      a = 8'($urandom); b = 8'($urandom);
      @(posedge clk); #1;
      checks++;
      if ({out_valid, in_ready, diff, borrow, ovf} !== {2'b10, 8'h87, 2'b00}) begin
        errors++;
        $display("FAIL bp stall[%0d]: got ov=%b ir=%b %h %b%b expected 1 0 87 00", i, out_valid, in_ready, diff, borrow, ovf);
      end
    end
    a = 8'h11; b = 8'h22; out_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL bp handshake: out_valid %b in_ready %b expected 0 1", out_valid, in_ready);
    end
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp queued accept: in_ready %b expected 0", in_ready); end
    in_valid = 1'b0;
    k = 0;
    while (!out_valid && k < 40) begin @(posedge clk); #1; k++; end
    checks++; if ({out_valid, diff, borrow, ovf} !== {1'b1, 8'hEF, 2'b10}) begin
      errors++; $display("FAIL bp queued result: got %b %h %b%b expected 1 ef 10", out_valid, diff, borrow, ovf);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_run();
    logic [7:0] d;
    logic bo, ov;
    int lat;
    out_ready = 1'b1;
    a = 8'h99; b = 8'h11; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if ({out_valid, in_ready} !== 2'b01) begin
      errors++; $display("FAIL midrst handshake: out_valid %b in_ready %b expected 0 1", out_valid, in_ready);
    end
    checks++; if ({diff, borrow, ovf} !== 10'b0) begin
      errors++; $display("FAIL midrst outputs: got %h %b%b expected 00 00", diff, borrow, ovf);
    end
    run_op(8'd3, 8'd5, d, bo, ov, lat);
    checks++; if ({d, bo, ov} !== {8'hFE, 2'b10}) begin
      errors++; $display("FAIL midrst fresh op: got %h %b%b expected fe 10", d, bo, ov);
    end
  endtask

  task automatic test_back_to_back_w8(input int n);
    logic [15:0] q [$];
    int done;
    done = 0;
    fork
      begin
        int w;
        logic [7:0] ra, rb;
        for (int i = 0; i < n; i++) begin
          ra = 8'($urandom); rb = 8'($urandom);
          in_valid = 1'b0;
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
          a = ra; b = rb; in_valid = 1'b1;
          w = 0;
          while (!in_ready && w < 200) begin @(posedge clk); #1; w++; end
          if (w >= 200) begin
            errors++; $display("FAIL b2b w8 accept timeout: op %0d", i);
            break;
          end
          q.push_back({ra, rb});
          @(posedge clk); #1;
          in_valid = 1'b0; a = 8'($urandom); b = 8'($urandom);
        end
        in_valid = 1'b0;
      end
      begin
        int cyc, ia, ib, sa, sb, sd;
        logic [15:0] op;
        logic [9:0] exp_r;
        cyc = 0;
        while (done < n && cyc < n * 60) begin
          out_ready = ($urandom_range(0, 3) != 0);
          if (out_valid && out_ready) begin
            checks++;
            if (q.size() == 0) begin
              errors++; $display("FAIL b2b w8 extra result: got %h", diff);
            end else begin
              op = q.pop_front();
              ia = int'(op[15:8]); ib = int'(op[7:0]);
              sa = (ia >= 128) ? ia - 256 : ia;
              sb = (ib >= 128) ? ib - 256 : ib;
              sd = sa - sb;
              exp_r = {8'(ia - ib), (ia < ib), (sd > 127 || sd < -128)};
              if ({diff, borrow, ovf} !== exp_r) begin
                errors++;
                $display("FAIL b2b w8 %0d-%0d: got %h %b%b expected %h %b%b", ia, ib, diff, borrow, ovf, exp_r[9:2], exp_r[1], exp_r[0]);
              end
            end
            done++;
          end
          @(posedge clk); #1;
          cyc++;
        end
        out_ready = 1'b0;
        checks++; if (done != n) begin errors++; $display("FAIL b2b w8 results: got %0d expected %0d", done, n); end
      end
    join
  endtask

  task automatic test_back_to_back_w2(input int n);
    logic [3:0] q [$];
    int done;
    done = 0;
    fork
      begin
        int w;
        logic [1:0] ra, rb;
        for (int i = 0; i < n; i++) begin
          ra = 2'($urandom); rb = 2'($urandom);
          in_valid2 = 1'b0;
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
          a2 = ra; b2 = rb; in_valid2 = 1'b1;
          w = 0;
          while (!in_ready2 && w < 200) begin @(posedge clk); #1; w++; end
          if (w >= 200) begin
            errors++; $display("FAIL b2b w2 accept timeout: op %0d", i);
            break;
          end
          q.push_back({ra, rb});
          @(posedge clk); #1;
          in_valid2 = 1'b0; a2 = 2'($urandom); b2 = 2'($urandom);
        end
        in_valid2 = 1'b0;
      end
      begin
        int cyc, ia, ib, sa, sb, sd;
        logic [3:0] op;
        logic [3:0] exp_r;
        cyc = 0;
        while (done < n && cyc < n * 60) begin
          out_ready2 = ($urandom_range(0, 3) != 0);
          if (out_valid2 && out_ready2) begin
            checks++;
            if (q.size() == 0) begin
              errors++; $display("FAIL b2b w2 extra result: got %h", diff2);
            end else begin
              op = q.pop_front();
              ia = int'(op[3:2]); ib = int'(op[1:0]);
              sa = (ia >= 2) ? ia - 4 : ia;
              sb = (ib >= 2) ? ib - 4 : ib;
              sd = sa - sb;
              exp_r = {2'(ia - ib), (ia < ib), (sd > 1 || sd < -2)};
              if ({diff2, borrow2, ovf2} !== exp_r) begin
                errors++;
                $display("FAIL b2b w2 %0d-%0d: got %h %b%b expected %h %b%b", ia, ib, diff2, borrow2, ovf2, exp_r[3:2], exp_r[1], exp_r[0]);
              end
            end
            done++;
          end
          @(posedge clk); #1;
          cyc++;
        end
        out_ready2 = 1'b0;
        checks++; if (done != n) begin errors++; $display("FAIL b2b w2 results: got %0d expected %0d", done, n); end
      end
    join
  endtask

  initial begin
    test_reset();
    test_basic();
    test_arith();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back_w8(1000);
    test_back_to_back_w2(1000);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
